// File: rtl/lsu_access_ctrl.sv
// Memory-stage load/store access controller.
// Checks alignment, raises address-error exceptions, runs a single outstanding
// request/addr_ok/data_ok access on an SRAM-like bus, builds byte strobes and
// replicated store data, and extends load data from the addressed lane.
module lsu_access_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter bit STRICT_ALIGN = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    input  logic [3:0]          in_op,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic                flush,
    output logic                stall,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_rdata,
    output logic                laddr_err,
    output logic                saddr_err,
    output logic [ADDR_W-1:0]   bad_vaddr,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata
);
    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t              state, stateNext;
    logic [3:0]          opReg;
    logic [ADDR_W-1:0]   addrReg;
    logic [DATA_W-1:0]   wdataReg;

    // Doubleword and LWU encodings only exist on a 64-bit bus.
    function automatic logic isLoadOp(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: isLoadOp = 1'b1;
            4'b0110, 4'b0111:                            isLoadOp = (DATA_W == 64);
            default:                                     isLoadOp = 1'b0;
        endcase
    endfunction

    function automatic logic isStoreOp(input logic [3:0] op);
        case (op)
            4'b1001, 4'b1010, 4'b1011: isStoreOp = 1'b1;
            4'b1100:                   isStoreOp = (DATA_W == 64);
            default:                   isStoreOp = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] opSize(input logic [3:0] op);
        case (op)
            4'b0011, 4'b0100, 4'b1010: opSize = 2'd1;
            4'b0101, 4'b0110, 4'b1011: opSize = 2'd2;
            4'b0111, 4'b1100:          opSize = 2'd3;
            default:                   opSize = 2'd0;
        endcase
    endfunction

    // Low address bits that must be zero for an access of this size.
    function automatic logic [ADDR_W-1:0] alignMask(input logic [1:0] size);
        alignMask = ADDR_W'((1 << size) - 1);
    endfunction

    function automatic logic [NB-1:0] laneStrobe(input logic [1:0] size,
                                                 input logic [LANE_W-1:0] lane);
        logic [NB-1:0] base;
        case (size)
            2'd0:    base = NB'(1);
            2'd1:    base = NB'(3);
            2'd2:    base = NB'(15);
            default: base = '1;
        endcase
        laneStrobe = base << lane;
    endfunction

    function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size,
                                                    input logic [DATA_W-1:0] d);
        case (size)
            2'd0:    replicate = {NB{d[7:0]}};
            2'd1:    replicate = {(NB/2){d[15:0]}};
            2'd2:    replicate = {(NB/4){d[31:0]}};
            default: replicate = d;
        endcase
    endfunction

    // Input is already shifted so the addressed lane sits at bit 0.
    function automatic logic [DATA_W-1:0] extendLoad(input logic [3:0] op,
                                                     input logic [DATA_W-1:0] d);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        b = d[7:0];
        h = d[15:0];
        w = d[31:0];
        case (op)
            4'b0001: extendLoad = DATA_W'(b);
            4'b0010: extendLoad = DATA_W'(d[7:0]);
            4'b0011: extendLoad = DATA_W'(h);
            4'b0100: extendLoad = DATA_W'(d[15:0]);
            4'b0101: extendLoad = DATA_W'(w);
            4'b0110: extendLoad = DATA_W'(d[31:0]);
            4'b0111: extendLoad = d;
            default: extendLoad = '0;
        endcase
    endfunction

    logic             inLoad, inStore, inActive, inErr, doAccept, busActive, regStore;
    logic [1:0]       inSize, regSize;
    logic [LANE_W-1:0] regLane;

    assign inLoad    = isLoadOp(in_op);
    assign inStore   = isStoreOp(in_op);
    assign inSize    = opSize(in_op);
    assign inActive  = in_valid && (inLoad || inStore) && !flush;
    assign inErr     = inActive && STRICT_ALIGN && ((in_addr & alignMask(inSize)) != '0);

    assign busActive = (state == REQ);
    assign regStore  = isStoreOp(opReg);
    assign regSize   = opSize(opReg);
    assign regLane   = addrReg[LANE_W-1:0];

    assign data_wr    = busActive && regStore;
    assign data_size  = busActive ? regSize : 2'd0;
    assign data_addr  = busActive ? addrReg : '0;
    assign data_wstrb = data_wr ? laneStrobe(regSize, regLane) : '0;
    assign data_wdata = data_wr ? replicate(regSize, wdataReg) : '0;
    assign out_rdata  = (out_valid && isLoadOp(opReg))
                      ? extendLoad(opReg, data_rdata >> {regLane, 3'b000}) : '0;

    // Next-state, handshake, stall and exception decode.
    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        out_valid = 1'b0;
        laddr_err = 1'b0;
        saddr_err = 1'b0;
        data_req  = 1'b0;
        doAccept  = 1'b0;
        case (state)
            IDLE: begin
                if (inErr) begin
                    laddr_err = inLoad;
                    saddr_err = inStore;
                end else if (inActive) begin
                    stall     = 1'b1;
                    doAccept  = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                stall    = 1'b1;
                data_req = 1'b1;
                if (data_addr_ok) stateNext = flush ? DRAIN : WAIT;
                else if (flush)   stateNext = IDLE;
            end
            WAIT: begin
                if (data_data_ok) begin
                    out_valid = 1'b1;
                    stateNext = IDLE;
                end else begin
                    stall = 1'b1;
                    if (flush) stateNext = DRAIN;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (data_data_ok) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register and faulting-address capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            bad_vaddr <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && inErr) bad_vaddr <= in_addr;
        end
    end

    // Access capture on accept; address forced to the access size boundary.
    always_ff @(posedge clk) begin
        if (doAccept) begin
            opReg    <= in_op;
            addrReg  <= in_addr & ~alignMask(inSize);
            wdataReg <= in_wdata;
        end
    end
endmodule

// File: doc/lsu_access_ctrl.md
Name: lsu_access_ctrl

Overview:
- Memory-stage load/store access controller for the MIPS core, replacing the purely combinational misalignment check.
- Checks alignment and raises load/store address-error exceptions, capturing BadVAddr.
- Drives an SRAM-like data bus with a request/address-ok/data-ok handshake and stalls the pipeline while an access is outstanding.
- Generates byte strobes and replicated write data, extracts and extends load data, and discards flushed accesses safely.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data bus width; legal values are 32 and 64. Doubleword ops exist only when DATA_W=64.
- STRICT_ALIGN, 1:
  - 1 = misaligned access raises an exception and issues no bus request.
  - 0 = low address bits are forced to zero for the access size and no exception is raised.

Ports:
- clk  in  1  clock; rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory op present in the M stage.
- in_op  in  4  access op:
  - 0000 none
  - 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 0110 LWU, 0111 LD
  - 1001 SB, 1010 SH, 1011 SW, 1100 SD
  - all other codes reserved (treated as none).
- in_addr  in  ADDR_W  effective virtual address.
- in_wdata  in  DATA_W  store data, right-justified.
- flush  in  1  exception/ERET flush of the M stage.
- stall  out  1  freeze the pipeline.
- out_valid  out  1  one-cycle completion pulse.
- out_rdata  out  DATA_W  extended load data; 0 for stores.
- laddr_err  out  1  load address error.
- saddr_err  out  1  store address error.
- bad_vaddr  out  ADDR_W  faulting address, registered.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- data_addr  out  ADDR_W  bus address.
- data_wstrb  out  DATA_W/8  byte strobes.
- data_wdata  out  DATA_W  lane-replicated write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response valid.
- data_rdata  in  DATA_W  read data.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, bus/result outputs 0, bad_vaddr=0. Reset mid-access abandons the access; the bus is reset by the same signal.
- Op classes:
  - LWU, LD, SD with DATA_W=32 are treated as none.
  - Size: half = LH/LHU/SH; word = LW/LWU/SW; dword = LD/SD.
- Misalignment conditions: half addr[0]!=0; word addr[1:0]!=0; dword addr[2:0]!=0.
- FSM: IDLE, REQ, WAIT, DRAIN. Only one access is outstanding at a time.
- IDLE with in_valid, op!=none and flush=0:
  - Misaligned and STRICT_ALIGN=1: laddr_err or saddr_err=1 combinationally in that cycle; bad_vaddr<=in_addr at the edge; no request; stall=0; stay in IDLE.
  - Otherwise: accept. Latch op, addr (masked when STRICT_ALIGN=0) and wdata; stall=1 combinationally; next state REQ.
- REQ:
  - data_req=1. Address, size, wr, wstrb and wdata are held stable until data_addr_ok=1.
  - addr_ok -> WAIT.
  - data_data_ok in REQ is ignored.
- WAIT:
  - data_req=0.
  - On data_data_ok: out_valid=1 for exactly that cycle and stall=0 that same cycle; next state IDLE.
- Stall: stall=1 from the accept cycle through every REQ/WAIT/DRAIN cycle, except the data_ok completion cycle.
- Latency: minimum 3 cycles, with out_valid in cycle 2 counting the accept cycle as 0.
- Strobes and write data (lane = addr[log2(DATA_W/8)-1:0]):
  - SB: one strobe bit at the lane; byte replicated across all lanes.
  - SH: two strobe bits at the lane; half replicated across the bus.
  - SW: four strobe bits at the lane; word replicated across the bus.
  - SD: all strobe bits set.
  - Loads: wstrb=0.
- Load data: select the lane from data_rdata, then:
  - LB/LH/LW: sign-extend to DATA_W.
  - LBU/LHU/LWU: zero-extend to DATA_W.
  - LD: pass through.
- Flush:
  - IDLE: no accept and no error.
  - REQ with addr_ok=0: drop the request; next state IDLE; no out_valid.
  - REQ with addr_ok=1 in the same cycle: go to DRAIN.
  - WAIT with data_ok=0: go to DRAIN.
  - WAIT with data_ok=1 in the same cycle: the access completes normally, with out_valid.
- DRAIN: stall=1; wait for data_ok, swallow it (out_valid=0), then return to IDLE.
- Error outputs are never asserted outside IDLE; bad_vaddr changes only on an error.

Test Plan:
- LW addr 0x80001000, rdata 0xDEADBEEF, addr_ok at cycle 1, data_ok at cycle 2 -> data_req high in cycle 1 only; out_valid pulse at cycle 2 with out_rdata=0xDEADBEEF; stall high in cycles 0-1.
- LB addr 0x...1003, rdata 0x80FF0000 -> out_rdata=0xFFFFFF80; the same access as LBU -> 0x00000080.
- SH addr 0x2002, wdata 0x1234 -> wstrb=1100, data_wdata=0x12341234; addr_ok held low 3 cycles -> req, addr and wdata stable throughout.
- LW addr 0x1001 (STRICT_ALIGN=1) -> laddr_err=1 that cycle, bad_vaddr=0x1001 next cycle, no data_req, stall=0. SW addr 0x1002 -> saddr_err=1. With STRICT_ALIGN=0, LW addr 0x1001 -> data_addr=0x1000, no error.
- Flush in WAIT, data_ok 2 cycles later -> no out_valid and stall held through DRAIN. A new LW presented during DRAIN is accepted only after return to IDLE.
- resetn low during WAIT -> state IDLE and all outputs 0 immediately; a new access after reset completes normally.
